aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
- Sequences the team's combinational one-round AES-128 key-expansion stage to generate all 11 round keys from a cipher key.
- Stores the keys in an internal 11x128 register file.
- Serves the keys to the cipher round datapath through a registered read port.
- Sits between the UART key-load path (upstream) and the AES round core (downstream). It drives the expansion stage's key/round inputs and consumes its round-key output.

Parameters:
- NR, 10, number of AES rounds; the store holds NR+1 keys, indexed 0..NR.
- KW, 128, key and round-key width in bits.

Ports:
- i_Clk  input  1  system clock; all state updates on the rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  load i_Key and begin expansion; sampled only in IDLE or READY.
- i_Key  input  KW  cipher key; [127:96] = w0 … [31:0] = w3.
- o_ExpKey  output  KW  previous round key driven to the expansion stage.
- o_ExpRnd  output  4  round index driven to the expansion stage (selects Rcon: 0 gives 01 … 9 gives 36).
- i_ExpRoundKey  input  KW  next round key returned by the expansion stage (combinational from o_ExpKey/o_ExpRnd).
- i_RdAddr  input  4  round-key read index.
- o_RdKey  output  KW  registered round-key read data.
- o_Busy  output  1  high while expanding.
- o_Ready  output  1  high while all 11 keys are valid.
- o_Done  output  1  one-cycle pulse when expansion completes.

Behaviour:
- Reset (async, i_Rst_n=0):
  - state=IDLE, cnt=0, all 11 store slots=0.
  - o_RdKey=0, o_Busy=0, o_Ready=0, o_Done=0.
  - o_ExpKey=0, o_ExpRnd=0.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY, i_Start=1 at edge E0:
  - slot[0] <= i_Key, cnt <= 0, state <= EXPAND.
  - o_Busy=1 and o_Ready=0 from E0.
  - Restart from READY invalidates the old key set.
- EXPAND, each edge:
  - slot[cnt+1] <= i_ExpRoundKey, cnt <= cnt+1.
  - o_ExpKey = slot[cnt] and o_ExpRnd = cnt (combinational from registers).
- Completion: at the edge with cnt==NR-1 (edge E10):
  - write slot[NR], state <= READY, cnt <= 0.
  - o_Busy=0, o_Ready=1, o_Done=1 for exactly the cycle following E10.
  - Total latency: 10 cycles from the start edge to o_Ready.
- Outside EXPAND: o_ExpKey=0 and o_ExpRnd=0.
- i_Start while in EXPAND: ignored; no restart, no effect on cnt or slots.
- Read port:
  - o_RdKey <= slot[i_RdAddr] every edge, 1-cycle latency, in all states.
  - i_RdAddr > NR: o_RdKey <= 0.
  - Data is guaranteed valid only while o_Ready=1; during EXPAND, reads return whatever the slot currently holds.
- Reset asserted mid-expansion: immediate return to IDLE with everything cleared; no o_Done pulse.
- No arithmetic beyond the 4-bit cnt increment; cnt never exceeds NR-1 in EXPAND.

Optional Feature:
- Macro: AES_KS_DEC_ORDER_EN.
- When defined:
  - Adds input i_fDec (1 bit).
  - When i_fDec=1, the read index is mapped to slot[NR - i_RdAddr] for i_RdAddr <= NR, so the decrypt core walks an ascending counter and gets keys in reverse order.
  - i_RdAddr > NR still returns 0.
  - When i_fDec=0, direct mapping.
- When undefined: i_fDec port absent; always direct mapping.

Test Plan:
- Common bench setup: the expansion stage (golden model) is connected to o_ExpKey/o_ExpRnd/i_ExpRoundKey.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse i_Start -> o_Done pulses on cycle 10 after the start edge, o_Ready=1; read addr 1 -> a0fafe1788542cb123a339392a6c7605 one cycle later; read addr 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- From READY, i_Start with key 0 -> o_Ready drops for 10 cycles; then addr 0 -> 0 and addr 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- i_Start pulsed at cycle 4 of EXPAND with a different key -> ignored; completion still on cycle 10 with the original key's schedule.
- i_Rst_n low at cycle 5 of EXPAND -> all outputs 0 immediately, no o_Done; a following i_Start with the FIPS key completes normally.
- i_RdAddr=11 and 15 -> o_RdKey=0.
- With AES_KS_DEC_ORDER_EN: i_fDec=1, addr 0 -> d014f9a8c9ee2589e13f0cc8b6630ca6; addr 10 -> 2b7e151628aed2a6abf7158809cf4f3c.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Key-schedule bus between the key loader, the expansion stage and the round core.
// Optional AES_KS_DEC_ORDER_EN adds the i_fDec reverse-order read select.
interface aes_key_schedule_if #(
    parameter int KW = 128
);
    logic          i_Start;
    logic [KW-1:0] i_Key;
    logic [KW-1:0] o_ExpKey;
    logic [3:0]    o_ExpRnd;
    logic [KW-1:0] i_ExpRoundKey;
    logic [3:0]    i_RdAddr;
    logic [KW-1:0] o_RdKey;
    logic          o_Busy;
    logic          o_Ready;
    logic          o_Done;
`ifdef AES_KS_DEC_ORDER_EN
    logic          i_fDec;
`endif

    modport slave (
        input  i_Start, i_Key, i_ExpRoundKey, i_RdAddr,
`ifdef AES_KS_DEC_ORDER_EN
        input  i_fDec,
`endif
        output o_ExpKey, o_ExpRnd, o_RdKey, o_Busy, o_Ready, o_Done
    );

    modport master (
        output i_Start, i_Key, i_ExpRoundKey, i_RdAddr,
`ifdef AES_KS_DEC_ORDER_EN
        output i_fDec,
`endif
        input  o_ExpKey, o_ExpRnd, o_RdKey, o_Busy, o_Ready, o_Done
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key schedule sequencer: drives an external one-round expansion stage,
// stores NR+1 round keys, serves them on a registered read port. Option: AES_KS_DEC_ORDER_EN.
module aes_key_schedule #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input logic                i_Clk,
    input logic                i_Rst_n,
    aes_key_schedule_if.slave  ks
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    localparam logic [3:0] LAST_RND = 4'(NR - 1);
    localparam logic [3:0] MAX_IDX  = 4'(NR);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [KW-1:0] slot [0:NR];
    logic          done_q;
    logic [KW-1:0] rd_q;
    logic [KW-1:0] rd_next;
    logic [KW-1:0] exp_key;
    logic [3:0]    rd_idx;
    logic          start_ok;
    logic          last_rnd;

    assign start_ok = ks.i_Start && (state == IDLE || state == READY);
    assign last_rnd = (state == EXPAND) && (cnt == LAST_RND);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_rnd;
            case (state)
                IDLE, READY: begin
                    if (ks.i_Start) begin
                        state <= EXPAND;
                        cnt   <= '0;
                    end
                end
                EXPAND: begin
                    if (last_rnd) begin
                        state <= READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int unsigned i = 0; i <= NR; i++) slot[i] <= '0;
        end else if (start_ok) begin
            slot[0] <= ks.i_Key;
        end else if (state == EXPAND) begin
            for (int unsigned i = 1; i <= NR; i++)
                if (cnt == 4'(i - 1)) slot[i] <= ks.i_ExpRoundKey;
        end
    end

    always_comb begin
        exp_key = '0;
        if (state == EXPAND)
            for (int unsigned i = 0; i < NR; i++)
                if (cnt == 4'(i)) exp_key = slot[i];
    end

    assign ks.o_ExpKey = exp_key;
    assign ks.o_ExpRnd = (state == EXPAND) ? cnt : '0;
    assign ks.o_Busy   = (state == EXPAND);
    assign ks.o_Ready  = (state == READY);
    assign ks.o_Done   = done_q;

    // Reverse mapping may wrap for out-of-range addresses; those are zeroed from the raw address.
`ifdef AES_KS_DEC_ORDER_EN
    assign rd_idx = ks.i_fDec ? (MAX_IDX - ks.i_RdAddr) : ks.i_RdAddr;
`else
    assign rd_idx = ks.i_RdAddr;
`endif

    always_comb begin
        rd_next = '0;
        if (ks.i_RdAddr <= MAX_IDX)
            for (int unsigned i = 0; i <= NR; i++)
                if (rd_idx == 4'(i)) rd_next = slot[i];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) rd_q <= '0;
        else          rd_q <= rd_next;
    end

    assign ks.o_RdKey = rd_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: behavioural expansion stage plus word-level FIPS-197 key-expansion reference.
module tb_aes_key_schedule;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0]   sbox [0:255];
    logic [127:0] ref_keys [0:10];

    aes_key_schedule_if #(.KW(128)) ks ();

    aes_key_schedule #(.NR(10), .KW(128)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .ks      (ks)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < int'(rnd); i++) r = xtime(r);
        return r;
    endfunction

    // Stand-in for the combinational one-round expansion stage.
    function automatic logic [127:0] stage(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(rnd), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign ks.i_ExpRoundKey = stage(ks.o_ExpKey, ks.o_ExpRnd);

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [127:0] exp, input string tag);
        ks.i_RdAddr = addr;
        step();
        check(tag, ks.o_RdKey, exp);
    endtask

    // Starts an expansion; optionally pulses i_Start with inj_key after inj_at cycles.
    task automatic run_expand(input logic [127:0] key, input int inj_at, input logic [127:0] inj_key);
        int lat = -1;
        ref_expand(key);
        ks.i_Key   = key;
        ks.i_Start = 1'b1;
        step();
        ks.i_Start = 1'b0;
        check("busy_e0", 128'(ks.o_Busy), 128'd1);
        check("ready_e0", 128'(ks.o_Ready), 128'd0);
        for (int k = 0; k <= 20 && lat < 0; k++) begin
            if (k > 0) step();
            ks.i_Start = 1'b0;
            if (ks.o_Done) lat = k;
            else if (k <= 9) begin
                check($sformatf("exp_rnd_%0d", k), 128'(ks.o_ExpRnd), 128'(k));
                check($sformatf("exp_key_%0d", k), ks.o_ExpKey, ref_keys[k]);
            end
            if (k == inj_at) begin
                ks.i_Key   = inj_key;
                ks.i_Start = 1'b1;
            end
        end
        ks.i_Start = 1'b0;
        check("done_latency", 128'(lat), 128'd10);
        check("ready_after", 128'(ks.o_Ready), 128'd1);
        check("busy_after", 128'(ks.o_Busy), 128'd0);
        check("expkey_idle", ks.o_ExpKey, 128'd0);
        step();
        check("done_pulse_end", 128'(ks.o_Done), 128'd0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a <= 10; a++)
            rd(4'(a), ref_keys[a], $sformatf("%s_rd%0d", tag, a));
    endtask

    initial begin
        rst_n          = 1'b0;
        ks.i_Start     = 1'b0;
        ks.i_Key       = '0;
        ks.i_RdAddr    = '0;
`ifdef AES_KS_DEC_ORDER_EN
        ks.i_fDec      = 1'b0;
`endif
        build_sbox();
        #12;
        check("rst_rdkey", ks.o_RdKey, 128'd0);
        check("rst_busy", 128'(ks.o_Busy), 128'd0);
        check("rst_ready", 128'(ks.o_Ready), 128'd0);
        check("rst_done", 128'(ks.o_Done), 128'd0);
        check("rst_expkey", ks.o_ExpKey, 128'd0);
        check("rst_exprnd", 128'(ks.o_ExpRnd), 128'd0);
        step();
        rst_n = 1'b1;
        step();

        run_expand(FIPS_KEY, -1, '0);
        rd(4'd1, FIPS_K1, "fips_k1");
        rd(4'd10, FIPS_K10, "fips_k10");
        read_all("fips");

        run_expand(128'd0, -1, '0);
        rd(4'd0, 128'd0, "zero_k0");
        rd(4'd10, ZERO_K10, "zero_k10");

        for (int n = 0; n < 4; n++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom}, -1, '0);
            read_all($sformatf("rand%0d", n));
        end

        run_expand(FIPS_KEY, 4, {$urandom, $urandom, $urandom, $urandom});
        rd(4'd10, FIPS_K10, "ignored_start_k10");
        read_all("ignored_start");

        // Reset mid-expansion
        ks.i_Key   = {$urandom, $urandom, $urandom, $urandom};
        ks.i_Start = 1'b1;
        step();
        ks.i_Start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(ks.o_Busy), 128'd0);
        check("midrst_ready", 128'(ks.o_Ready), 128'd0);
        check("midrst_rdkey", ks.o_RdKey, 128'd0);
        check("midrst_expkey", ks.o_ExpKey, 128'd0);
        check("midrst_exprnd", 128'(ks.o_ExpRnd), 128'd0);
        repeat (8) begin
            step();
            check("midrst_no_done", 128'(ks.o_Done), 128'd0);
        end
        rst_n = 1'b1;
        step();
        run_expand(FIPS_KEY, -1, '0);
        rd(4'd10, FIPS_K10, "post_rst_k10");

        rd(4'd11, 128'd0, "oob_11");
        rd(4'd15, 128'd0, "oob_15");
        for (int n = 0; n < 12; n++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            rd(a, (a <= 4'd10) ? ref_keys[a] : 128'd0, $sformatf("rand_rd_%0d", a));
        end

`ifdef AES_KS_DEC_ORDER_EN
        ks.i_fDec = 1'b1;
        rd(4'd0, FIPS_K10, "dec_rd0");
        rd(4'd10, FIPS_KEY, "dec_rd10");
        for (int a = 0; a <= 15; a++)
            rd(4'(a), (a <= 10) ? ref_keys[10 - a] : 128'd0, $sformatf("dec_rd%0d", a));
        ks.i_fDec = 1'b0;
        rd(4'd0, FIPS_KEY, "dec_off_rd0");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
